// File: rtl/sys_defs.sv
// Shared types for the ROB retire path: retire packet, ROB entry, XLEN/ZERO_REG and default ROB size.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package sys_defs;

  localparam int ROB_SZ_DEFAULT = 8;

  typedef struct packed {
    logic [4:0]       r;
    logic [`XLEN-1:0] V;
  } ROB_RETIRE_DATA;

  typedef struct packed {
    ROB_RETIRE_DATA data_retired;
  } ROB_RT_PACKET;

  typedef struct packed {
    logic             valid;
    logic             complete;
    logic [4:0]       r;
    logic [`XLEN-1:0] V;
  } ROB_ENTRY;

endpackage
`endif

// File: rtl/rob_wrap_ptr.sv
// W-bit modulo pointer with synchronous clear and increment; wraps naturally at 2**W.
module rob_wrap_ptr #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_retire_head.sv
// In-order completion buffer retiring one head entry per cycle as a registered ROB_RT_PACKET.
// Optional ROB_CDB_BYPASS_EN lets a CDB hitting an incomplete head retire it at the same edge.
module rob_retire_head
  import sys_defs::*;
#(
  parameter int ROB_SZ = ROB_SZ_DEFAULT,
  parameter int TAG_W  = $clog2(ROB_SZ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic [4:0]        dispatch_r,
  output logic              dispatch_ready,
  output logic [TAG_W-1:0]  dispatch_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [`XLEN-1:0]  cdb_value,
  input  logic              squash,
  output ROB_RT_PACKET      rob_rt_packet,
  output logic              retire_valid,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(ROB_SZ);
  localparam logic [TAG_W:0] CNT_ONE  = (TAG_W+1)'(1);

  ROB_ENTRY         rob_q [ROB_SZ];
  ROB_ENTRY         rob_d [ROB_SZ];
  logic [TAG_W:0]   count_q, count_d;
  ROB_RT_PACKET     pkt_q, pkt_d;
  logic             rv_q, rv_d;
  logic [TAG_W-1:0] head, tail;

  logic             disp_fire;
  logic             head_ready;
  logic             head_byp;
  logic             retire;
  ROB_ENTRY         head_ent;

  assign head_ent       = rob_q[head];
  assign dispatch_ready = (count_q < CNT_FULL);
  assign disp_fire      = dispatch_valid && dispatch_ready;
  assign head_ready     = head_ent.valid && head_ent.complete;

`ifdef ROB_CDB_BYPASS_EN
  assign head_byp = head_ent.valid && !head_ent.complete && cdb_valid && (cdb_tag == head);
`else
  assign head_byp = 1'b0;
`endif

  assign retire = head_ready || head_byp;

  rob_wrap_ptr #(.W(TAG_W)) u_head_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (squash),
    .inc   (retire),
    .ptr   (head)
  );

  rob_wrap_ptr #(.W(TAG_W)) u_tail_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (squash),
    .inc   (disp_fire),
    .ptr   (tail)
  );

  always_comb begin
    rob_d                   = rob_q;
    pkt_d                   = '0;
    pkt_d.data_retired.r    = `ZERO_REG;
    rv_d                    = 1'b0;
    count_d                 = count_q;

    if (cdb_valid && rob_q[cdb_tag].valid) begin
      rob_d[cdb_tag].V        = cdb_value;
      rob_d[cdb_tag].complete = 1'b1;
    end

    // Retire clears the head after any CDB write so a late repeat CDB cannot resurrect it.
    if (retire) begin
      pkt_d.data_retired.r = head_ent.r;
      pkt_d.data_retired.V = head_byp ? cdb_value : head_ent.V;
      rv_d                 = 1'b1;
      rob_d[head]          = '0;
    end

    if (disp_fire) begin
      rob_d[tail].valid    = 1'b1;
      rob_d[tail].complete = 1'b0;
      rob_d[tail].r        = dispatch_r;
      rob_d[tail].V        = '0;
    end

    if (disp_fire && !retire)      count_d = count_q + CNT_ONE;
    else if (!disp_fire && retire) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int i = 0; i < ROB_SZ; i++) rob_q[i] <= '0;
      count_q                 <= '0;
      pkt_q                   <= '0;
      pkt_q.data_retired.r    <= `ZERO_REG;
      rv_q                    <= 1'b0;
    end else begin
      for (int i = 0; i < ROB_SZ; i++) rob_q[i] <= rob_d[i];
      count_q <= count_d;
      pkt_q   <= pkt_d;
      rv_q    <= rv_d;
    end
  end

  assign dispatch_tag  = tail;
  assign rob_rt_packet = pkt_q;
  assign retire_valid  = rv_q;
  assign count         = count_q;

endmodule
